// File: rtl/nios_pio_in_edge_pkg.sv
// Shared constants for the Nios II parallel input PIO.
// Register map words and edge-type selectors.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DIR      = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// readdata is combinational from the slave.
interface nios_pio_in_edge_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios_pio_sync.sv
// WIDTH x STAGES synchroniser chain with async reset.
// Reusable by any PIO that samples asynchronous pins.
module nios_pio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++)
        ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++)
        ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO with sticky edge capture and a
// level irq raised by any unmasked captured edge.
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  nios_pio_in_edge_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [2:0]       warm_cnt;
  logic             warm;
  logic             wr;
  logic             wr_mask;
  logic             wr_cap;
  logic             unused_wd;

  nios_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (data)
  );

  assign unused_wd = ^bus.writedata;

  assign wr      = bus.chipselect && !bus.write_n;
  assign wr_mask = wr && (bus.address == ADDR_IRQ_MASK);
  assign wr_cap  = wr && (bus.address == ADDR_EDGE_CAP);

  assign warm = (warm_cnt == WARM);
  assign rise = data & ~prev;
  assign fall = ~data & prev;

  always_comb begin
    sel = rise;
    if (EDGE_TYPE == EDGE_FALLING)
      sel = fall;
    else if (EDGE_TYPE == EDGE_ANY)
      sel = rise | fall;
  end

  // prev and sync flops both start at 0, so hold off
  // until the chain holds real pin samples
  assign det = warm ? sel : '0;
  assign clr = wr_cap ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (!warm)
        warm_cnt <= warm_cnt + 3'd1;
      prev <= data;
      if (wr_mask)
        irq_mask <= bus.writedata[WIDTH-1:0];
      // a new edge beats a same-cycle W1C clear
      edge_cap <= (edge_cap & ~clr) | det;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:     bus.readdata = 32'(data);
      ADDR_DIR:      bus.readdata = '0;
      ADDR_IRQ_MASK: bus.readdata = 32'(irq_mask);
      ADDR_EDGE_CAP: bus.readdata = 32'(edge_cap);
    endcase
  end

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Directed bench for nios_pio_in_edge: rising and any-edge
// instances checked against a pin-history model every cycle.
`timescale 1ns/100ps
module tb_nios_pio_in_edge;
  import nios_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [15:0] in_port;
  logic        irq0;
  logic        irq2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios_pio_in_edge_if bus0 ();
  nios_pio_in_edge_if bus2 ();

  assign bus0.address    = addr;
  assign bus0.chipselect = cs;
  assign bus0.write_n    = wn;
  assign bus0.writedata  = wd;
  assign bus2.address    = addr;
  assign bus2.chipselect = cs;
  assign bus2.write_n    = wn;
  assign bus2.writedata  = wd;

  nios_pio_in_edge #(
    .WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .in_port(in_port), .irq(irq0)
  );

  nios_pio_in_edge #(
    .WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .in_port(in_port), .irq(irq2)
  );

  logic [31:0] rdv [2];
  logic        irqv [2];
  assign rdv[0]  = bus0.readdata;
  assign rdv[1]  = bus2.readdata;
  assign irqv[0] = irq0;
  assign irqv[1] = irq2;

  // Model: h0/h1/h2 = pin value sampled 0/1/2 edges ago.
  // DATA is the pin two samples back (h1 after the edge),
  // and an edge is DATA vs the sample before it.
  logic [15:0] h0, h1, h2;
  logic [15:0] m_mask [2];
  logic [15:0] m_ec   [2];
  logic        m_irq  [2];
  int          since_rst;
  int          etype [2] = '{0, 2};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 = '0; h1 = '0; h2 = '0;
      since_rst = 0;
      for (int k = 0; k < 2; k++) begin
        m_mask[k] = '0; m_ec[k] = '0; m_irq[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic logic [15:0] up = h1 & ~h2;
        automatic logic [15:0] dn = ~h1 & h2;
        automatic logic [15:0] ev;
        automatic logic [15:0] wc = '0;
        ev = (etype[k] == 0) ? up :
             (etype[k] == 1) ? dn : (up | dn);
        if (since_rst < 3) ev = '0;
        if (cs && !wn && addr == 2'd3) wc = wd[15:0];
        m_irq[k] = |(m_ec[k] & m_mask[k]);
        m_ec[k]  = (m_ec[k] & ~wc) | ev;
        if (cs && !wn && addr == 2'd2) m_mask[k] = wd[15:0];
      end
      h2 = h1; h1 = h0; h0 = in_port;
      if (since_rst < 3) since_rst++;
    end
  end

  function automatic logic [31:0] exp_rd(int k);
    case (addr)
      2'd0:    return {16'h0, h1};
      2'd2:    return {16'h0, m_mask[k]};
      2'd3:    return {16'h0, m_ec[k]};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (rdv[k] !== exp_rd(k) || irqv[k] !== m_irq[k]) begin
          miscompares++;
          $display("FAIL model dut%0d a=%0d: rd=%h irq=%b want rd=%h irq=%b",
                   k * 2, addr, rdv[k], irqv[k], exp_rd(k), m_irq[k]);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr = a; wd = d; cs = 1'b1; wn = 1'b0;
    tick();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(int k, logic [1:0] a, string nm, logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdv[k], exp);
  endtask

  initial begin
    reset_n = 1'b0;
    addr = 2'd0; cs = 1'b0; wn = 1'b1; wd = '0;
    in_port = 16'hFFFF;
    repeat (3) tick();
    rd(0, ADDR_DATA, "rst_data", 32'h0);
    chk("rst_irq", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;

    repeat (10) tick();
    rd(0, ADDR_DATA, "hold_data", 32'h0000FFFF);
    rd(0, ADDR_EDGE_CAP, "hold_cap", 32'h0);
    rd(1, ADDR_EDGE_CAP, "hold_cap_any", 32'h0);
    chk("hold_irq", {30'h0, irq2, irq0}, 32'h0);

    in_port = 16'h0000;
    repeat (6) tick();
    wr(ADDR_EDGE_CAP, 32'h0000FFFF);
    wr(ADDR_IRQ_MASK, 32'h00000001);
    in_port = 16'h0001;
    tick();
    rd(0, ADDR_DATA, "lat_e1_data", 32'h0);
    tick();
    rd(0, ADDR_DATA, "lat_e2_data", 32'h1);
    rd(0, ADDR_EDGE_CAP, "lat_e2_cap", 32'h0);
    tick();
    rd(0, ADDR_EDGE_CAP, "lat_e3_cap", 32'h1);
    chk("lat_e3_irq", {31'h0, irq0}, 32'h0);
    tick();
    chk("lat_e4_irq", {31'h0, irq0}, 32'h1);

    in_port = 16'h0005;
    repeat (4) tick();
    rd(0, ADDR_EDGE_CAP, "w1c_pre", 32'h5);
    wr(ADDR_EDGE_CAP, 32'h00000004);
    rd(0, ADDR_EDGE_CAP, "w1c_a", 32'h1);
    chk("w1c_a_irq", {31'h0, irq0}, 32'h1);
    wr(ADDR_EDGE_CAP, 32'h00000001);
    rd(0, ADDR_EDGE_CAP, "w1c_b", 32'h0);
    chk("w1c_b_irq_lag", {31'h0, irq0}, 32'h1);
    tick();
    chk("w1c_b_irq", {31'h0, irq0}, 32'h0);

    in_port = 16'h0007;
    repeat (4) tick();
    rd(0, ADDR_EDGE_CAP, "col_pre", 32'h2);
    wr(ADDR_IRQ_MASK, 32'h00000002);
    tick();
    chk("col_irq_on", {31'h0, irq0}, 32'h1);
    in_port = 16'h0005;
    repeat (4) tick();
    in_port = 16'h0007;
    tick();
    tick();
    wr(ADDR_EDGE_CAP, 32'h00000002);
    rd(0, ADDR_EDGE_CAP, "col_cap", 32'h2);
    chk("col_irq", {31'h0, irq0}, 32'h1);
    tick();
    chk("col_irq_hold", {31'h0, irq0}, 32'h1);

    wr(ADDR_IRQ_MASK, 32'h0);
    wr(ADDR_EDGE_CAP, 32'h0000FFFF);
    in_port = 16'h000F;
    repeat (3) tick();
    in_port = 16'h0007;
    repeat (5) tick();
    rd(0, ADDR_EDGE_CAP, "mask_cap", 32'h8);
    rd(1, ADDR_EDGE_CAP, "mask_cap_any", 32'h8);
    chk("mask_irq_off", {31'h0, irq0}, 32'h0);
    wr(ADDR_IRQ_MASK, 32'h00000008);
    chk("mask_irq_lag", {31'h0, irq0}, 32'h0);
    tick();
    chk("mask_irq_on", {31'h0, irq0}, 32'h1);

    wr(ADDR_DATA, 32'hDEADBEEF);
    wr(ADDR_DIR, 32'hDEADBEEF);
    rd(0, ADDR_DATA, "ign_data", 32'h7);
    rd(0, ADDR_DIR, "rsvd_rd", 32'h0);
    rd(0, ADDR_IRQ_MASK, "ign_mask", 32'h8);
    tick();
    rd(0, ADDR_EDGE_CAP, "ign_cap", 32'h8);
    chk("ign_irq", {31'h0, irq0}, 32'h1);

    wr(ADDR_IRQ_MASK, 32'h0);
    wr(ADDR_EDGE_CAP, 32'h0000FFFF);
    in_port = 16'h0006;
    repeat (5) tick();
    wr(ADDR_EDGE_CAP, 32'h0000FFFF);
    in_port = 16'h0007;
    tick();
    tick();
    in_port = 16'h0006;
    repeat (6) tick();
    rd(1, ADDR_EDGE_CAP, "pulse_any", 32'h1);
    rd(0, ADDR_EDGE_CAP, "pulse_rise", 32'h1);

    wr(ADDR_IRQ_MASK, 32'h00000001);
    tick();
    chk("pre_rst_irq", {31'h0, irq0}, 32'h1);
    reset_n = 1'b0;
    rd(0, ADDR_EDGE_CAP, "mid_rst_cap", 32'h0);
    chk("mid_rst_irq", {31'h0, irq0}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(0, ADDR_DATA, "rst2_data", 32'h6);
    rd(0, ADDR_EDGE_CAP, "rst2_cap", 32'h0);
    rd(1, ADDR_EDGE_CAP, "rst2_cap_any", 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_pio_in_edge.md
Name: nios_pio_in_edge

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the system's output PIOs. It samples an external parallel bus such as switches, buttons or a counter feedback.
- Synchronises in_port, exposes it as a readable data register and captures per-bit edges into a sticky edge-capture register.
- Raises a level-sensitive irq to the Nios II when any captured edge is unmasked.
- Sits on the Nios data master alongside the output PIOs.
- Zero wait states: readdata is combinational, read latency 0.

Parameters:
- WIDTH, 16: number of input bits (1..32).
- SYNC_STAGES, 2: synchroniser flop depth (2..4).
- EDGE_TYPE, 0: edge to capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, combinational.
- irq  out  1  interrupt request, registered, level.

Behaviour:
- Reset:
  - Synchroniser flops, prev register, data, irq_mask, edge_capture and irq are all 0.
  - Warm-up counter is cleared.
  - Reset is asserted asynchronously and released synchronously to clk.
- Register map (word addresses):
  - 0 DATA: RO, synchronised in_port.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAPTURE: R/W1C.
- Read path:
  - readdata = zero-extended selected register, driven whenever address is valid; chipselect is not required for read data.
  - Bits above WIDTH read 0.
- Write:
  - Accepted when chipselect && !write_n.
  - IRQ_MASK <= writedata[WIDTH-1:0].
  - EDGE_CAPTURE: each bit with writedata[i]=1 is cleared; bits with 0 are unchanged.
  - Writes to addresses 0 and 1 have no effect.
- Synchroniser: in_port passes through SYNC_STAGES flops; the last stage is DATA.
- Edge detect:
  - prev <= DATA every cycle.
  - rise = DATA & ~prev; fall = ~DATA & prev; sel = rise, fall or rise|fall per EDGE_TYPE.
  - Detection is suppressed until the warm-up counter reaches SYNC_STAGES+1 cycles after reset release. This prevents spurious edges from reset values.
  - The warm-up counter saturates.
- Capture:
  - edge_capture[i] <= 1 on sel[i]; it is sticky until cleared by W1C.
  - A set and a W1C clear on the same bit in the same cycle: the set wins and the bit stays 1.
- IRQ: irq <= |(edge_capture & irq_mask), registered one cycle after capture or mask change.
- Latency (SYNC_STAGES=2, warm-up complete), with the in_port change sampled at clk edge 1:
  - DATA updates after edge 2.
  - edge_capture bit sets at edge 3.
  - irq asserts at edge 4.
- Pulse handling:
  - Pulses shorter than one clock may be missed; no requirement applies to them.
  - A pulse of at least 2 clocks is always captured for EDGE_TYPE 2.
- Mask behaviour:
  - Masking does not prevent capture.
  - Unmasking an already-set capture bit raises irq one cycle after the mask write.
- Clearing behaviour:
  - Clearing the last unmasked set bit deasserts irq one cycle after the write.
  - A new edge arriving in the same cycle as the clear keeps irq high.
- Reset mid-operation: all state returns to reset values immediately and the warm-up restarts.

Decomposition:
- Package nios_pio_pkg:
  - Address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3.
  - Edge-type constants EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
- Sub-module nios_pio_sync:
  - Parameterised WIDTH × SYNC_STAGES flop chain with async reset.
  - Reusable by other input PIOs.
- The remaining logic (regs, edge detect, irq) stays in the top module.

Test Plan:
- Reset hold test: hold in_port=16'hFFFF through reset, release, wait 10 cycles. Required: DATA reads 0x0000FFFF; EDGE_CAPTURE reads 0; irq stays 0.
- Rising-edge latency test (EDGE_TYPE=0, mask=0x0001): in_port 0x0000→0x0001 sampled at edge 1. Required: DATA=1 after edge 2; EDGE_CAPTURE=0x1 after edge 3; irq=1 after edge 4.
- W1C test (EDGE_CAPTURE=0x0005): write 0x0004 to address 3. Required: readback 0x1 and irq still high. Then write 0x1: readback 0 and irq low one cycle later.
- Set-clear collision test: write 0x0002 to address 3 in the same cycle bit 1 detects a new edge. Required: bit 1 stays 1 and irq stays high.
- Mask test: with mask=0, toggle bit 3. Required: capture=0x8 and irq=0. Then write mask 0x8: irq=1 one cycle after the write.
- Ignored-write and reserved-address test: write 0xDEADBEEF to addresses 0 and 1. Required: no state change, and address 1 reads 0. With EDGE_TYPE=2, a 2-cycle high pulse on bit 0 captures bit 0.
